barrel_shifter_pipe: RTL and testbench



---
 rtl/shifter_pkg.sv | 23 ++
 rtl/shifter_stage.sv | 130 +++++++++++++
 rtl/barrel_shifter_pipe.sv | 153 +++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: opcode encoding and field widths.
package shifter_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LSR = 3'b000,
    OP_LSL = 3'b001,
    OP_ASR = 3'b010,
    OP_ROR = 3'b011,
    OP_ROL = 3'b100
  } shifter_op_e;

  // Stage payload {op, amt, data, carry} at the default 8-bit width; the
  // parametrised modules carry the same fields as individually sized ports.
  typedef struct packed {
    shifter_op_e op;
    logic [3:0]  amt;
    logic [7:0]  data;
    logic        carry;
  } stage_payload_t;

endpackage

// File: rtl/shifter_stage.sv
// One registered log stage: shifts/rotates by 2**K when amount bit K is set.
// The carry port exists only when SHIFTER_FLAGS_EN is defined.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned K     = 0,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [WIDTH-1:0] in_data,
`ifdef SHIFTER_FLAGS_EN
  input  logic             in_carry,
  output logic             out_carry,
  output logic [WIDTH-1:0] nxt_data,
`endif
  output logic             out_valid,
  output logic [OP_W-1:0]  out_op,
  output logic [AMT_W-1:0] out_amt,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned S = 1 << K;

  logic             valid_d, valid_q;
  logic [OP_W-1:0]  op_d, op_q;
  logic [AMT_W-1:0] amt_d, amt_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [WIDTH-1:0] sh_data;
`ifdef SHIFTER_FLAGS_EN
  logic             carry_d, carry_q;
  logic             sh_carry;
`endif

  always_comb begin
    sh_data = in_data;
`ifdef SHIFTER_FLAGS_EN
    sh_carry = in_carry;
`endif
    if (in_amt[K]) begin
      case (in_op)
        OP_LSR: begin
          sh_data = in_data >> S;
`ifdef SHIFTER_FLAGS_EN
          sh_carry = in_data[S-1];
`endif
        end
        OP_LSL: begin
          sh_data = in_data << S;
`ifdef SHIFTER_FLAGS_EN
          sh_carry = in_data[WIDTH-S];
`endif
        end
        OP_ASR: begin
          sh_data = WIDTH'($signed(in_data) >>> S);
`ifdef SHIFTER_FLAGS_EN
          sh_carry = in_data[S-1];
`endif
        end
        OP_ROR: begin
          sh_data = (in_data >> S) | (in_data << (WIDTH - S));
`ifdef SHIFTER_FLAGS_EN
          sh_carry = sh_data[WIDTH-1];
`endif
        end
        OP_ROL: begin
          sh_data = (in_data << S) | (in_data >> (WIDTH - S));
`ifdef SHIFTER_FLAGS_EN
          sh_carry = sh_data[0];
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    amt_d   = amt_q;
    data_d  = data_q;
`ifdef SHIFTER_FLAGS_EN
    carry_d = carry_q;
`endif
    if (advance) begin
      valid_d = in_valid;
      op_d    = in_op;
      amt_d   = in_amt;
      data_d  = sh_data;
`ifdef SHIFTER_FLAGS_EN
      carry_d = sh_carry;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      amt_q   <= '0;
      data_q  <= '0;
`ifdef SHIFTER_FLAGS_EN
      carry_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      data_q  <= data_d;
`ifdef SHIFTER_FLAGS_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_amt   = amt_q;
  assign out_data  = data_q;
`ifdef SHIFTER_FLAGS_EN
  assign out_carry = carry_q;
  assign nxt_data  = sh_data;
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator, log2(WIDTH) registered stages, valid/ready flow control.
// Define SHIFTER_FLAGS_EN to add the out_zero/out_carry result flags.
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  localparam int unsigned SHAMT_W = $clog2(WIDTH),
  localparam int unsigned AMT_W   = SHAMT_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFTER_FLAGS_EN
  output logic             out_zero,
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);

  logic                advance;
  logic [SHAMT_W-1:0]  amt_lo;
  logic                over;
  logic [WIDTH-1:0]    pre_data;
  logic [AMT_W-1:0]    pre_amt;

  logic                st_valid [SHAMT_W];
  logic [OP_W-1:0]     st_op    [SHAMT_W];
  logic [AMT_W-1:0]    st_amt   [SHAMT_W];
  logic [WIDTH-1:0]    st_data  [SHAMT_W];
`ifdef SHIFTER_FLAGS_EN
  logic                pre_carry;
  logic                st_carry [SHAMT_W];
  logic [WIDTH-1:0]    st_nxt   [SHAMT_W];
  logic                zero_d, zero_q;
`endif

  assign out_valid = st_valid[SHAMT_W-1];
  assign out_data  = st_data[SHAMT_W-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  assign amt_lo = in_amt[SHAMT_W-1:0];
  assign over   = in_amt[AMT_W-1];

  // Overshift and reserved opcodes are resolved here so the log stages only
  // ever see an in-range amount; the amount MSB is cleared for every op.
  always_comb begin
    pre_data = in_data;
    pre_amt  = {1'b0, amt_lo};
`ifdef SHIFTER_FLAGS_EN
    pre_carry = 1'b0;
`endif
    case (in_op)
      OP_LSR, OP_LSL: begin
        if (over) begin
          pre_data = '0;
          pre_amt  = '0;
`ifdef SHIFTER_FLAGS_EN
          if (amt_lo == '0)
            pre_carry = (in_op == OP_LSR) ? in_data[WIDTH-1] : in_data[0];
`endif
        end
      end
      OP_ASR: begin
        if (over) begin
          pre_data = {WIDTH{in_data[WIDTH-1]}};
          pre_amt  = '0;
`ifdef SHIFTER_FLAGS_EN
          pre_carry = in_data[WIDTH-1];
`endif
        end
      end
      OP_ROR, OP_ROL: ;
      default: begin
        pre_data = '0;
        pre_amt  = '0;
      end
    endcase
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic             v_in;
    logic [OP_W-1:0]  op_in;
    logic [AMT_W-1:0] amt_in;
    logic [WIDTH-1:0] data_in;
`ifdef SHIFTER_FLAGS_EN
    logic             carry_in;
`endif

    if (k == 0) begin : g_first
      assign v_in    = in_valid;
      assign op_in   = in_op;
      assign amt_in  = pre_amt;
      assign data_in = pre_data;
`ifdef SHIFTER_FLAGS_EN
      assign carry_in = pre_carry;
`endif
    end else begin : g_rest
      assign v_in    = st_valid[k-1];
      assign op_in   = st_op[k-1];
      assign amt_in  = st_amt[k-1];
      assign data_in = st_data[k-1];
`ifdef SHIFTER_FLAGS_EN
      assign carry_in = st_carry[k-1];
`endif
    end

    shifter_stage #(
      .WIDTH (WIDTH),
      .K     (k),
      .AMT_W (AMT_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .in_valid  (v_in),
      .in_op     (op_in),
      .in_amt    (amt_in),
      .in_data   (data_in),
`ifdef SHIFTER_FLAGS_EN
      .in_carry  (carry_in),
      .out_carry (st_carry[k]),
      .nxt_data  (st_nxt[k]),
`endif
      .out_valid (st_valid[k]),
      .out_op    (st_op[k]),
      .out_amt   (st_amt[k]),
      .out_data  (st_data[k])
    );
  end

`ifdef SHIFTER_FLAGS_EN
  always_comb begin
    zero_d = zero_q;
    if (advance) zero_d = (st_nxt[SHAMT_W-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end

  assign out_zero  = zero_q;
  assign out_carry = st_carry[SHAMT_W-1];
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed and randomised self-checking bench for barrel_shifter_pipe at WIDTH=8.
module tb_barrel_shifter_pipe;
  import shifter_pkg::*;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_amt;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef SHIFTER_FLAGS_EN
  logic       out_zero;
  logic       out_carry;
`endif

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SHIFTER_FLAGS_EN
    .out_zero  (out_zero),
    .out_carry (out_carry),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned n_out = 0;

  function automatic logic [7:0] ref_data(input logic [2:0] op, input logic [3:0] amt,
                                          input logic [7:0] d);
    logic [15:0] dd;
    logic [15:0] t;
    int unsigned r;
    dd = {d, d};
    r  = amt % W;
    case (op)
      3'd0: return (amt >= W) ? 8'h00 : (d >> amt);
      3'd1: return (amt >= W) ? 8'h00 : (d << amt);
      3'd2: return (amt >= W) ? {8{d[7]}} : 8'($signed(d) >>> amt);
      3'd3: begin t = dd >> r; return t[7:0];  end
      3'd4: begin t = dd << r; return t[15:8]; end
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [2:0] op, input logic [3:0] amt,
                                     input logic [7:0] d);
    int unsigned a;
    logic [7:0]  res;
    a   = amt;
    res = ref_data(op, amt, d);
    case (op)
      3'd0: return (a == 0) ? 1'b0 : (a <= W) ? d[a-1] : 1'b0;
      3'd1: return (a == 0) ? 1'b0 : (a <= W) ? d[W-a] : 1'b0;
      3'd2: return (a == 0) ? 1'b0 : (a <= W) ? d[a-1] : d[7];
      3'd3: return (a % W == 0) ? 1'b0 : res[7];
      3'd4: return (a % W == 0) ? 1'b0 : res[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; one transaction, checked 3 cycles after acceptance.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [3:0] amt,
                         input logic [7:0] d, input logic [7:0] exp_d, input logic exp_c);
    in_valid = 1'b1; in_op = op; in_amt = amt; in_data = d; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
`ifdef SHIFTER_FLAGS_EN
    chk({tag, "_carry"}, 32'(out_carry), 32'(exp_c));
    chk({tag, "_zero"}, 32'(out_zero), 32'(exp_d == 8'h00));
`else
    if (exp_c === 1'bx) $display("note: %s carry expectation undefined", tag);
`endif
    @(posedge clk); @(negedge clk); #1;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  // Called at a falling edge; drives one cycle, scores any output transfer.
  task automatic step(input logic iv, input logic [2:0] op, input logic [3:0] amt,
                      input logic [7:0] d, input logic ordy, input logic stall_chk,
                      output logic acc, output logic got);
    exp_t e;
    in_valid = iv; in_op = op; in_amt = amt; in_data = d; out_ready = ordy;
    #1;
    acc = iv && in_ready;
    got = out_valid && ordy;
    if (stall_chk) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_data", 32'(out_data), 32'(exp_q[0].data));
    end
    if (got) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_output observed=%0h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_data", 32'(out_data), 32'(e.data));
`ifdef SHIFTER_FLAGS_EN
        chk("stream_carry", 32'(out_carry), 32'(e.carry));
        chk("stream_zero", 32'(out_zero), 32'(e.data == 8'h00));
`endif
      end
      n_out++;
    end
    if (acc) exp_q.push_back('{data: ref_data(op, amt, d), carry: ref_carry(op, amt, d)});
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  s_op  [6];
    logic [3:0]  s_amt [6];
    logic [7:0]  s_dat [6];
    logic        acc, got;
    int unsigned idx, out0, last_c, n_acc, cyc;

    s_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
    s_amt = '{4'd1, 4'd2, 4'd5, 4'd7, 4'd9, 4'd15};
    s_dat = '{8'h81, 8'h3C, 8'hC1, 8'h5A, 8'h96, 8'h7E};

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_amt = '0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("lsr3", 3'b000, 4'd3, 8'hB4, 8'h16, 1'b1);
    run_one("lsl3", 3'b001, 4'd3, 8'hB4, 8'hA0, 1'b1);
    run_one("asr3", 3'b010, 4'd3, 8'hB4, 8'hF6, 1'b1);
    run_one("ror3", 3'b011, 4'd3, 8'hB4, 8'h96, 1'b1);
    run_one("rol3", 3'b100, 4'd3, 8'hB4, 8'hA5, 1'b1);
    run_one("lsl9", 3'b001, 4'd9, 8'hFF, 8'h00, 1'b0);
    run_one("asr12", 3'b010, 4'd12, 8'h80, 8'hFF, 1'b1);
    run_one("rol11", 3'b100, 4'd11, 8'hB4, 8'hA5, 1'b1);
    run_one("rsvd6", 3'b110, 4'd3, 8'h5A, 8'h00, 1'b0);
    run_one("lsr0", 3'b000, 4'd0, 8'hC3, 8'hC3, 1'b0);
    run_one("lsr8", 3'b000, 4'd8, 8'h80, 8'h00, 1'b1);
    run_one("ror8", 3'b011, 4'd8, 8'hB4, 8'hB4, 1'b0);

    // Six back-to-back ops, consumer stalls for cycles 4..8.
    idx = 0; out0 = n_out; last_c = 0;
    for (int c = 0; c < 40 && (idx < 6 || exp_q.size() != 0); c++) begin
      if (idx < 6)
        step(1'b1, s_op[idx], s_amt[idx], s_dat[idx], !(c >= 4 && c < 9), (c >= 4 && c < 9), acc, got);
      else
        step(1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b0, acc, got);
      if (acc) idx++;
      if (got) last_c = c;
    end
    chk("stream_count", n_out - out0, 32'd6);
    chk("stream_last_cycle", last_c, 32'd13);
    chk("stream_queue_empty", exp_q.size(), 32'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 4'd1, 8'h11, 1'b0, 1'b0, acc, got);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      #1;
      chk("postrst_no_stale", 32'(out_valid), 32'd0);
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
    end

    // Random valid/ready traffic against the reference model.
    out0 = n_out; n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           8'($urandom), $urandom_range(0, 3) != 0, 1'b0, acc, got);
      if (acc) n_acc++;
      cyc++;
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      step(1'b0, 3'd0, 4'd0, 8'h00, 1'b1, 1'b0, acc, got);
    chk("rand_accepted", n_acc, 32'd10000);
    chk("rand_out_count", n_out - out0, 32'd10000);
    chk("rand_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
